// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Interlock and forwarding scheduler for the four-stage (IF, ID, EX, WB)
// core with eight 3-bit-addressed registers. It follows ALU results held in
// EX and WB and keeps a pending scoreboard for variable-latency loads. Each
// cycle it picks the operand source for the instruction sitting in ID, and
// decides whether that instruction issues, stalls, or (after a jump) has
// its IF/ID contents squashed.
//
// Parameters
//   MAX_LD      maximum number of loads allowed in flight (1..7)
//   JUMP_FLUSH  flush cycles inserted after a taken jump (1..3)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rdst / id_rsrc   ID destination-or-first-source / second source
//   id_wr               ID instruction writes id_rdst
//   id_rd_rdst/rsrc     ID instruction reads the matching operand
//   id_is_load/jump     ID instruction class
//   ld_done / ld_rdst   load return strobe and its destination register
//   fwd_rdst/fwd_rsrc   operand select: 00 RF, 01 EX, 10 WB, 11 load data
//   stall               hold PC and IF/ID
//   bubble              insert a NOP into EX
//   flush               squash IF/ID contents
//   ld_busy             loads in flight have reached MAX_LD
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MAX_LD     = 2,
  parameter int JUMP_FLUSH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_rdst,
  input  logic [2:0] id_rsrc,
  input  logic       id_wr,
  input  logic       id_rd_rdst,
  input  logic       id_rd_rsrc,
  input  logic       id_is_load,
  input  logic       id_is_jump,
  input  logic       ld_done,
  input  logic [2:0] ld_rdst,
  output logic [1:0] fwd_rdst,
  output logic [1:0] fwd_rsrc,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic       ld_busy
);

  localparam logic [2:0] MAX_LD_C     = 3'(MAX_LD);
  localparam logic [1:0] JUMP_FLUSH_C = 2'(JUMP_FLUSH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] flush_cnt;
  logic [1:0] flush_cnt_nxt;

  logic [7:0] pending;
  logic [7:0] pending_nxt;
  logic [2:0] ld_cnt;
  logic [2:0] ld_cnt_nxt;

  logic       ex_v;
  logic       ex_ld;
  logic [2:0] ex_rdst;
  logic       wb_v;
  logic [2:0] wb_rdst;

  logic       issue;
  logic       ld_hit_rdst;
  logic       ld_hit_rsrc;
  logic       ld_valid_done;
  logic       stall_raw;
  logic       ld_inc;
  logic       ld_dec;

  // Operand source for one register: the youngest producer wins, so an ALU
  // result in EX beats WB, which beats data arriving from memory this cycle.
  // A load sitting in EX has no result yet and is never a forward source.
  function automatic logic [1:0] fwd_sel(
    input logic       rd,
    input logic [2:0] r,
    input logic       e_v,
    input logic       e_ld,
    input logic [2:0] e_rdst,
    input logic       w_v,
    input logic [2:0] w_rdst,
    input logic       l_done,
    input logic [2:0] l_rdst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rd) begin
      if (e_v && !e_ld && (e_rdst == r)) begin
        sel = 2'b01;
      end else if (w_v && (w_rdst == r)) begin
        sel = 2'b10;
      end else if (l_done && (l_rdst == r)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  assign fwd_rdst = fwd_sel(id_rd_rdst, id_rdst, ex_v, ex_ld, ex_rdst,
                            wb_v, wb_rdst, ld_done, ld_rdst);
  assign fwd_rsrc = fwd_sel(id_rd_rsrc, id_rsrc, ex_v, ex_ld, ex_rdst,
                            wb_v, wb_rdst, ld_done, ld_rdst);

  assign ld_busy       = (ld_cnt == MAX_LD_C);
  assign ld_hit_rdst   = ld_done && (ld_rdst == id_rdst);
  assign ld_hit_rsrc   = ld_done && (ld_rdst == id_rsrc);
  assign ld_valid_done = ld_done && pending[ld_rdst];

  // Raw hazard check for the ID instruction. A pending register whose load
  // returns this very cycle is covered by the 11 forward path, so it only
  // blocks when the data is still outstanding. A load in EX blocks its
  // consumers regardless, since its data cannot be forwarded from EX.
  always_comb begin
    logic read_pend;
    logic load_use;
    logic waw;
    logic ld_full;
    read_pend = (id_rd_rdst && pending[id_rdst] && !ld_hit_rdst) ||
                (id_rd_rsrc && pending[id_rsrc] && !ld_hit_rsrc);
    load_use  = ex_v && ex_ld &&
                ((id_rd_rdst && (ex_rdst == id_rdst)) ||
                 (id_rd_rsrc && (ex_rdst == id_rsrc)));
    waw       = id_wr && pending[id_rdst] && !ld_hit_rdst;
    ld_full   = id_is_load && ld_busy;
    stall_raw = id_valid && (read_pend || load_use || waw || ld_full);
  end

  // Issue/flush control. In RUN the hazard check drives stall and bubble and
  // a stalled jump simply waits in ID. A jump that issues moves on to EX
  // normally; the flush window opens on the following cycle and lasts
  // JUMP_FLUSH cycles, during which nothing issues.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    stall         = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    issue         = 1'b0;
    case (state)
      RUN: begin
        stall  = stall_raw;
        bubble = stall_raw;
        issue  = id_valid && !stall_raw;
        if (issue && id_is_jump) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = JUMP_FLUSH_C;
        end
      end
      FLUSH: begin
        flush         = 1'b1;
        bubble        = 1'b1;
        flush_cnt_nxt = flush_cnt - 2'd1;
        if (flush_cnt <= 2'd1) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Scoreboard and load counter. Returns for registers that are not pending
  // (for example a load that was in flight across a reset) are ignored. When
  // a register is cleared and set in the same cycle the new load wins, and a
  // simultaneous issue and return leave the count unchanged.
  always_comb begin
    pending_nxt = pending;
    if (ld_valid_done) begin
      pending_nxt[ld_rdst] = 1'b0;
    end
    if (issue && id_is_load) begin
      pending_nxt[id_rdst] = 1'b1;
    end

    ld_inc     = issue && id_is_load && (ld_cnt < MAX_LD_C);
    ld_dec     = ld_valid_done && (ld_cnt != 3'd0);
    ld_cnt_nxt = ld_cnt;
    if (ld_inc && !ld_dec) begin
      ld_cnt_nxt = ld_cnt + 3'd1;
    end else if (ld_dec && !ld_inc) begin
      ld_cnt_nxt = ld_cnt - 3'd1;
    end
  end

  // State registers. EX captures whatever issues (or an empty slot); WB only
  // keeps ALU results, because load data reaches the RF through ld_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
      pending   <= 8'h00;
      ld_cnt    <= 3'd0;
      ex_v      <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rdst   <= 3'd0;
      wb_v      <= 1'b0;
      wb_rdst   <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pending   <= pending_nxt;
      ld_cnt    <= ld_cnt_nxt;
      ex_v      <= issue;
      ex_ld     <= id_is_load;
      ex_rdst   <= id_rdst;
      wb_v      <= ex_v && !ex_ld;
      wb_rdst   <= ex_rdst;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Randomized bench for hazard_ctrl. A reference model built from the
// interlock rules (a register file of pending flags, a load count, a
// remaining-flush count and a short history of issued instructions) predicts
// every output each cycle. Resets are injected asynchronously in mid-cycle.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MAX_LD     = 2;
  localparam int JUMP_FLUSH = 2;
  localparam int CYCLES     = 3000;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rdst;
  logic [2:0] id_rsrc;
  logic       id_wr;
  logic       id_rd_rdst;
  logic       id_rd_rsrc;
  logic       id_is_load;
  logic       id_is_jump;
  logic       ld_done;
  logic [2:0] ld_rdst;
  logic [1:0] fwd_rdst;
  logic [1:0] fwd_rsrc;
  logic       stall;
  logic       bubble;
  logic       flush;
  logic       ld_busy;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    bit valid;
    int rdst;
    bit isLoad;
  } issued_t;

  bit      modelPend [8];
  int      modelCnt;
  int      modelFlushLeft;
  issued_t history [$];

  int expFwdRdst;
  int expFwdRsrc;
  bit expStall;
  bit expBubble;
  bit expFlush;
  bit expBusy;
  bit expIssue;

  hazard_ctrl #(
    .MAX_LD     (MAX_LD),
    .JUMP_FLUSH (JUMP_FLUSH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rdst    (id_rdst),
    .id_rsrc    (id_rsrc),
    .id_wr      (id_wr),
    .id_rd_rdst (id_rd_rdst),
    .id_rd_rsrc (id_rd_rsrc),
    .id_is_load (id_is_load),
    .id_is_jump (id_is_jump),
    .ld_done    (ld_done),
    .ld_rdst    (ld_rdst),
    .fwd_rdst   (fwd_rdst),
    .fwd_rsrc   (fwd_rsrc),
    .stall      (stall),
    .bubble     (bubble),
    .flush      (flush),
    .ld_busy    (ld_busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports each check.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Instruction issued k cycles ago (k=1 sits in EX, k=2 in WB).
  function automatic issued_t issuedAgo(input int k);
    issued_t none;
    none.valid  = 1'b0;
    none.rdst   = 0;
    none.isLoad = 1'b0;
    if (history.size() >= k) return history[history.size() - k];
    return none;
  endfunction

  function automatic int expectedFwd(input bit rd, input int r);
    issued_t ex;
    issued_t wb;
    ex = issuedAgo(1);
    wb = issuedAgo(2);
    if (!rd) return 0;
    if (ex.valid && !ex.isLoad && ex.rdst == r) return 1;
    if (wb.valid && !wb.isLoad && wb.rdst == r) return 2;
    if (ld_done && int'(ld_rdst) == r) return 3;
    return 0;
  endfunction

  // A read operand is blocked if its load is still outstanding, or if the
  // instruction just ahead of it is the load producing it.
  function automatic bit readBlocked(input bit rd, input int r);
    issued_t ex;
    bit returning;
    ex = issuedAgo(1);
    returning = ld_done && int'(ld_rdst) == r;
    if (!rd) return 1'b0;
    if (modelPend[r] && !returning) return 1'b1;
    if (ex.valid && ex.isLoad && ex.rdst == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic computeExpected();
    bit inRun;
    bit waw;
    inRun      = (modelFlushLeft == 0);
    waw        = id_wr && modelPend[id_rdst] && !(ld_done && ld_rdst == id_rdst);
    expBusy    = (modelCnt == MAX_LD);
    expStall   = inRun && id_valid &&
                 (readBlocked(id_rd_rdst, int'(id_rdst)) ||
                  readBlocked(id_rd_rsrc, int'(id_rsrc)) ||
                  waw || (id_is_load && expBusy));
    expIssue   = inRun && id_valid && !expStall;
    expFlush   = !inRun;
    expBubble  = !inRun || expStall;
    expFwdRdst = expectedFwd(id_rd_rdst, int'(id_rdst));
    expFwdRsrc = expectedFwd(id_rd_rsrc, int'(id_rsrc));
  endtask

  task automatic compareAll();
    checkOutput("fwd_rdst", int'(fwd_rdst), expFwdRdst);
    checkOutput("fwd_rsrc", int'(fwd_rsrc), expFwdRsrc);
    checkOutput("stall",    int'(stall),    int'(expStall));
    checkOutput("bubble",   int'(bubble),   int'(expBubble));
    checkOutput("flush",    int'(flush),    int'(expFlush));
    checkOutput("ld_busy",  int'(ld_busy),  int'(expBusy));
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic advanceModel();
    issued_t rec;
    bit validDone;
    bit inc;
    bit dec;
    validDone = ld_done && modelPend[ld_rdst];
    if (validDone) modelPend[ld_rdst] = 1'b0;
    if (expIssue && id_is_load) modelPend[id_rdst] = 1'b1;
    inc = expIssue && id_is_load && modelCnt < MAX_LD;
    dec = validDone && modelCnt > 0;
    modelCnt = modelCnt + int'(inc) - int'(dec);
    if (modelFlushLeft > 0) modelFlushLeft--;
    else if (expIssue && id_is_jump) modelFlushLeft = JUMP_FLUSH;
    rec.valid  = expIssue;
    rec.rdst   = int'(id_rdst);
    rec.isLoad = id_is_load;
    history.push_back(rec);
    while (history.size() > 2) void'(history.pop_front());
  endtask

  task automatic clearModel();
    foreach (modelPend[i]) modelPend[i] = 1'b0;
    modelCnt       = 0;
    modelFlushLeft = 0;
    history.delete();
  endtask

  task automatic quietInputs();
    id_valid   = 1'b0;
    id_rdst    = 3'd0;
    id_rsrc    = 3'd0;
    id_wr      = 1'b0;
    id_rd_rdst = 1'b0;
    id_rd_rsrc = 1'b0;
    id_is_load = 1'b0;
    id_is_jump = 1'b0;
    ld_done    = 1'b0;
    ld_rdst    = 3'd0;
  endtask

  // Random ID instruction and load return. Registers are drawn mostly from
  // a small set so hazards are frequent, and returns mostly target a
  // register that is really pending.
  task automatic applyStimulus();
    int kind;
    int pendList [$];
    id_valid   = ($urandom_range(0, 9) < 8);
    id_rdst    = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(0, 7));
    id_rsrc    = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(0, 7));
    id_rd_rdst = ($urandom_range(0, 9) < 6);
    id_rd_rsrc = ($urandom_range(0, 9) < 7);
    kind       = $urandom_range(0, 99);
    id_is_load = (kind < 35);
    id_is_jump = (kind >= 35 && kind < 43);
    id_wr      = id_is_load ? 1'b1 : (id_is_jump ? 1'b0 : ($urandom_range(0, 9) < 8));
    ld_done    = ($urandom_range(0, 9) < 3);
    foreach (modelPend[i]) if (modelPend[i]) pendList.push_back(i);
    if (pendList.size() > 0 && $urandom_range(0, 9) < 8)
      ld_rdst = 3'(pendList[$urandom_range(0, pendList.size() - 1)]);
    else
      ld_rdst = 3'($urandom_range(0, 7));
  endtask

  // Assert reset away from any clock edge, confirm outputs drop at once,
  // hold through an edge, then release between edges.
  task automatic applyReset();
    @(posedge clk);
    #2;
    quietInputs();
    rst_n = 1'b0;
    clearModel();
    #1;
    computeExpected();
    compareAll();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    quietInputs();
    clearModel();
    applyReset();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      if (cyc % 300 == 299) applyReset();
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      computeExpected();
      compareAll();
      advanceModel();
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline interlock and forwarding scheduler for the 8-register, 3-bit-address processor core (IF, ID, EX, WB). It tracks ALU results in flight in EX and WB, plus variable-latency loads in an 8-entry pending scoreboard. Each cycle it issues operand forward selects for the ID instruction, and it decides whether ID issues, stalls, or a jump flushes IF/ID. It drives the ID operand muxes and the PC/IF-ID enable logic.

Parameters:
MAX_LD, 2, max outstanding loads (1..7); counter width 3 bits.
JUMP_FLUSH, 1, bubble cycles inserted after a taken jump (1..3).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rdst  in  3  ID destination / first source register
id_rsrc  in  3  ID second source register
id_wr  in  1  ID instruction writes id_rdst
id_rd_rdst  in  1  ID instruction reads id_rdst as an operand
id_rd_rsrc  in  1  ID instruction reads id_rsrc
id_is_load  in  1  ID instruction is a load
id_is_jump  in  1  ID instruction is a jump (always taken)
ld_done  in  1  load data returned this cycle; written to RF this cycle
ld_rdst  in  3  destination of the returning load
fwd_rdst  out  2  rdst operand select: 00 RF, 01 EX ALU, 10 WB result, 11 load return data
fwd_rsrc  out  2  rsrc operand select, same encoding
stall  out  1  hold PC and IF/ID register
bubble  out  1  insert NOP into EX
flush  out  1  squash IF/ID contents
ld_busy  out  1  outstanding-load count == MAX_LD

Behaviour:
- Reset (async, rst_n=0): pending=8'h00, ld_cnt=0, ex_v=0, wb_v=0, flush_cnt=0, state=RUN. Outputs: fwd_*=00, stall=0, bubble=0, flush=0, ld_busy=0.
- Internal tracking: ex_v/ex_rdst/ex_ld load from ID on issue. When ID does not issue, ex_v is loaded with 0. wb_v/wb_rdst load from EX only if ex_v & ~ex_ld.
- issue = id_valid & ~stall & state==RUN.
- Forward select, evaluated per operand r combinationally, in priority order:
  - ex_v & ~ex_ld & ex_rdst==r gives 01.
  - else wb_v & wb_rdst==r gives 10.
  - else ld_done & ld_rdst==r gives 11.
  - else 00.
- Forward selects are meaningful only when the matching id_rd_* is set. Otherwise they read 00.
- Stall condition (combinational, state RUN only). stall=1 if any of:
  - (a) a read operand r has pending[r]=1, and is not covered by ld_done & ld_rdst==r that cycle.
  - (b) a read operand matches ex_rdst with ex_v & ex_ld (load-use).
  - (c) id_wr & pending[id_rdst] (WAW against a load), unless cleared by ld_done that cycle.
  - (d) id_is_load & ld_busy.
- bubble=stall while in RUN.
- Scoreboard:
  - Set pending[id_rdst] on issue & id_is_load.
  - Clear pending[ld_rdst] on ld_done.
  - Same register set and cleared in the same cycle: set wins.
  - ld_done for a non-pending register is ignored; it does not clear and does not decrement.
- ld_cnt: +1 on load issue, -1 on valid ld_done; both together leave it unchanged. It is never allowed past MAX_LD or below 0.
- FSM:
  - RUN to FLUSH on issue & id_is_jump; load flush_cnt=JUMP_FLUSH.
  - In FLUSH: flush=1, bubble=1, stall=0, no issue, flush_cnt decrements.
  - FLUSH to RUN when flush_cnt reaches 1, at the end of that cycle.
- Jump issue cycle itself: flush=0; the jump proceeds to EX.
- Latency: all outputs are combinational from the current state and inputs. The scoreboard, counter and FSM update on the next edge.
- Reset mid-load: all pending cleared. Late ld_done after reset is ignored (not pending).
- Simultaneous jump and stall: the stall wins; the jump waits in ID.

Test Plan:
1. ALU back-to-back: issue r3<=..., then ID reads r3 -> fwd_rsrc=01, stall=0. Next cycle a third instruction reads r3 -> fwd=10.
2. Load-use: issue load r5, next ID reads r5 -> stall=1, bubble=1. With no ld_done, stall persists; on the ld_done/ld_rdst=5 cycle -> stall=0, fwd=11, pending[5] cleared.
3. MAX_LD=2: issue loads r1, r2, then a load r4 -> ld_busy=1, stall=1. ld_done r1 -> ld_busy drops, stall=0 the next cycle, r4 issues.
4. Jump with JUMP_FLUSH=2: issue jump -> two cycles of flush=1, bubble=1, then RUN with id_valid accepted again.
5. WAW: load r6 pending, ID ALU writes r6 -> stall until ld_done r6. A same-cycle ld_done r6 with a new load r6 issue -> pending[6] remains 1.
6. Async reset asserted mid-stall with pending=8'h22 -> all outputs 0 immediately, pending=0. A stale ld_done r1 after reset leaves ld_cnt=0.
